// File: rtl/draw_layer_arbiter.sv
// draw_layer_arbiter: fixed-priority pixel layer mux with once-per-frame collision pulses and a frame counter
module draw_layer_arbiter #(
  parameter logic [7:0] BORDER_RGB = 8'b111_111_00,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   shotDrawReq,
  input  logic                   bombDrawReq,
  input  logic                   playerDrawReq,
  input  logic                   aliensDrawReq,
  input  logic                   boardersDrawReq,
  input  logic [7:0]             shotRGB,
  input  logic [7:0]             bombRGB,
  input  logic [7:0]             playerRGB,
  input  logic [7:0]             aliensRGB,
  input  logic [7:0]             BG_RGB,
  output logic [7:0]             RGBOut,
  output logic                   shotAlienHit,
  output logic                   bombPlayerHit,
  output logic                   shotBorderHit,
  output logic [FRAME_CNT_W-1:0] frameCount
);
  typedef enum logic {ARMED, FIRED} hit_state_t;
  hit_state_t state [3];
  hit_state_t state_next [3];
  logic [2:0] coinc, fire, hit;
  logic [7:0] rgb_next;
  assign coinc = {shotDrawReq & boardersDrawReq, bombDrawReq & playerDrawReq, shotDrawReq & aliensDrawReq};
  assign rgb_next = shotDrawReq     ? shotRGB   :
                    bombDrawReq     ? bombRGB   :
                    playerDrawReq   ? playerRGB :
                    aliensDrawReq   ? aliensRGB :
                    boardersDrawReq ? BORDER_RGB : BG_RGB;
  // a coincidence on startOfFrame belongs to the new frame, so it fires regardless of the old state
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      fire[i] = coinc[i] & (startOfFrame | state[i] == ARMED);
      state_next[i] = coinc[i] ? FIRED : startOfFrame ? ARMED : state[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      RGBOut <= 8'h00;
      hit <= 3'b000;
      frameCount <= '0;
      for (int i = 0; i < 3; i++) state[i] <= ARMED;
    end else begin
      RGBOut <= rgb_next;
      hit <= fire;
      frameCount <= frameCount + FRAME_CNT_W'(startOfFrame);
      for (int i = 0; i < 3; i++) state[i] <= state_next[i];
    end
  end
  assign shotAlienHit = hit[0];
  assign bombPlayerHit = hit[1];
  assign shotBorderHit = hit[2];
endmodule

// File: tb/tb_draw_layer_arbiter.sv
// tb_draw_layer_arbiter: vector table, directed corner sequences and random stimulus against a frame-level reference model
module tb_draw_layer_arbiter;
  localparam int FW = 8;
  logic clk = 0, resetN = 0, startOfFrame = 0;
  logic shotDrawReq = 0, bombDrawReq = 0, playerDrawReq = 0, aliensDrawReq = 0, boardersDrawReq = 0;
  logic [7:0] shotRGB = 8'hE0, bombRGB = 8'h1C, playerRGB = 8'h4A, aliensRGB = 8'h92, BG_RGB = 8'h03;
  logic [7:0] RGBOut;
  logic shotAlienHit, bombPlayerHit, shotBorderHit;
  logic [FW-1:0] frameCount;
  int checks = 0, failures = 0;
  logic [7:0] m_rgb;
  logic [2:0] m_hit;
  int m_fc;
  bit [2:0] m_fired;

  draw_layer_arbiter #(.BORDER_RGB(8'b111_111_00), .FRAME_CNT_W(FW)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .shotDrawReq(shotDrawReq), .bombDrawReq(bombDrawReq), .playerDrawReq(playerDrawReq),
    .aliensDrawReq(aliensDrawReq), .boardersDrawReq(boardersDrawReq),
    .shotRGB(shotRGB), .bombRGB(bombRGB), .playerRGB(playerRGB), .aliensRGB(aliensRGB), .BG_RGB(BG_RGB),
    .RGBOut(RGBOut), .shotAlienHit(shotAlienHit), .bombPlayerHit(bombPlayerHit),
    .shotBorderHit(shotBorderHit), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic req(input logic [4:0] r);
    {shotDrawReq, bombDrawReq, playerDrawReq, aliensDrawReq, boardersDrawReq} = r;
  endtask

  function automatic logic [7:0] pick();
    logic [4:0] r;
    logic [7:0] c [5];
    r = {shotDrawReq, bombDrawReq, playerDrawReq, aliensDrawReq, boardersDrawReq};
    c = '{shotRGB, bombRGB, playerRGB, aliensRGB, 8'hFC};
    for (int i = 0; i < 5; i++) if (r[4-i]) return c[i];
    return BG_RGB;
  endfunction

  // model: a frame remembers which collision types it has already reported
  task automatic step(input string name);
    logic [2:0] c;
    c = {shotDrawReq & boardersDrawReq, bombDrawReq & playerDrawReq, shotDrawReq & aliensDrawReq};
    if (!resetN) begin
      m_rgb = 0; m_hit = 0; m_fc = 0; m_fired = 0;
    end else begin
      m_rgb = pick();
      if (startOfFrame) begin
        m_fc = (m_fc + 1) % (1 << FW);
        m_fired = 0;
      end
      for (int i = 0; i < 3; i++) begin
        m_hit[i] = c[i] && !m_fired[i];
        if (c[i]) m_fired[i] = 1;
      end
    end
    @(posedge clk);
    #1;
    cmp({name, "_rgb"}, 32'(RGBOut), 32'(m_rgb));
    cmp({name, "_hit"}, 32'({shotBorderHit, bombPlayerHit, shotAlienHit}), 32'(m_hit));
    cmp({name, "_fc"}, 32'(frameCount), 32'(m_fc));
  endtask

  typedef struct {
    logic [4:0] r;
    logic [7:0] bg;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int n;
    logic [31:0] rnd;
    tbl = '{
      '{5'b10111, 8'h03, 8'hE0},
      '{5'b00111, 8'h03, 8'h4A},
      '{5'b00000, 8'h03, 8'h03},
      '{5'b00001, 8'h55, 8'hFC},
      '{5'b01011, 8'h03, 8'h1C},
      '{5'b00011, 8'h00, 8'h92}
    };
    #1;
    req(5'b11111);
    startOfFrame = 1;
    step("reset");
    cmp("reset_rgb_zero", 32'(RGBOut), 0);
    cmp("reset_fc_zero", 32'(frameCount), 0);
    startOfFrame = 0;
    req(0);
    resetN = 1;
    for (int i = 0; i < 6; i++) begin
      req(tbl[i].r);
      BG_RGB = tbl[i].bg;
      step("tbl");
      cmp("tbl_const_rgb", 32'(RGBOut), 32'(tbl[i].exp));
    end
    BG_RGB = 8'h03;
    req(0);
    startOfFrame = 1;
    step("opf_sof");
    startOfFrame = 0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      req(5'b10010);
      step("opf_coinc");
      if (k == 0) cmp("opf_first_pulse", 32'(shotAlienHit), 1);
      n += int'(shotAlienHit);
      req(0);
      step("opf_gap");
      n += int'(shotAlienHit);
    end
    cmp("opf_pulse_count", n, 1);
    startOfFrame = 1;
    step("opf_sof2");
    startOfFrame = 0;
    req(5'b10010);
    step("opf_new_frame");
    cmp("opf_new_pulse", 32'(shotAlienHit), 1);
    req(5'b01100);
    step("sim_bp_fire");
    req(0);
    step("sim_gap");
    req(5'b01100);
    startOfFrame = 1;
    step("sim_sof_coinc");
    cmp("sim_sof_bp_pulse", 32'(bombPlayerHit), 1);
    req(5'b11111);
    step("sim_sof_all");
    cmp("sim_all_three", 32'({shotBorderHit, bombPlayerHit, shotAlienHit}), 3'b111);
    startOfFrame = 0;
    req(0);
    resetN = 0;
    step("rst_mid");
    resetN = 1;
    startOfFrame = 1;
    repeat (5) step("pre5");
    startOfFrame = 0;
    cmp("pre5_fc", 32'(frameCount), 5);
    req(5'b10001);
    step("sb_fire");
    req(5'b10001);
    resetN = 0;
    step("sb_reset");
    cmp("sb_reset_hits", 32'({shotBorderHit, bombPlayerHit, shotAlienHit}), 0);
    cmp("sb_reset_fc", 32'(frameCount), 0);
    cmp("sb_reset_rgb", 32'(RGBOut), 0);
    resetN = 1;
    step("sb_after");
    cmp("sb_after_pulse", 32'(shotBorderHit), 1);
    req(0);
    startOfFrame = 1;
    step("async_pre");
    startOfFrame = 0;
    resetN = 0;
    #3;
    cmp("async_no_effect_fc", 32'(frameCount), 1);
    step("async_edge");
    resetN = 1;
    startOfFrame = 1;
    repeat (256) step("wrap");
    startOfFrame = 0;
    cmp("wrap_fc_zero", 32'(frameCount), 0);
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      req(rnd[4:0]);
      startOfFrame = ($urandom % 12) == 0;
      resetN = ($urandom % 50) != 0;
      shotRGB = 8'($urandom); bombRGB = 8'($urandom); playerRGB = 8'($urandom);
      aliensRGB = 8'($urandom); BG_RGB = 8'($urandom);
      step("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/draw_layer_arbiter.md
DRAW_LAYER_ARBITER -- requirements
Module: draw_layer_arbiter

Interface
REQ-001 Parameter BORDER_RGB, default 8'b111_111_00, is the colour driven when the border layer wins.
REQ-002 Parameter FRAME_CNT_W, default 8, is the width of frameCount.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port startOfFrame, input, 1 bit: one-cycle pulse marking the first pixel of a frame.
REQ-006 Ports shotDrawReq, bombDrawReq, playerDrawReq, aliensDrawReq and boardersDrawReq, inputs, 1 bit each: layer draw requests for the current pixel.
REQ-007 Ports shotRGB, bombRGB, playerRGB, aliensRGB and BG_RGB, inputs, 8 bits each: layer colours in RRRGGGBB format.
REQ-008 Port RGBOut, output, 8 bits: the arbitrated pixel colour, registered.
REQ-009 Ports shotAlienHit, bombPlayerHit and shotBorderHit, outputs, 1 bit each: collision pulses.
REQ-010 Port frameCount, output, FRAME_CNT_W bits: count of frames seen.

Function
REQ-011 The fixed priority, highest first, SHALL be shot > bomb > player > aliens > borders > background.
- RGBOut takes the RGB of the highest-priority asserted request.
- The border layer drives BORDER_RGB.
- With no request asserted, RGBOut takes BG_RGB.
REQ-012 RGBOut latency SHALL be exactly 1 clk from the inputs to the output.
- The output SHALL hold its value only when recomputed each cycle; no stalls.
REQ-013 Coincidences SHALL be evaluated on the same-cycle inputs:
- shotAlien = shotDrawReq & aliensDrawReq.
- bombPlayer = bombDrawReq & playerDrawReq.
- shotBorder = shotDrawReq & boardersDrawReq.
REQ-014 Each collision type SHALL have a 2-state FSM, ARMED and FIRED; the reset state SHALL be ARMED.
REQ-015 ARMED -> FIRED when a coincidence occurs; the matching output SHALL pulse high for exactly 1 clk, in the cycle after the coincidence.
REQ-016 In the FIRED state, further coincidences SHALL produce no pulse; the FSM returns to ARMED only on startOfFrame.
- Result: at most one pulse per type per frame.
REQ-017 If startOfFrame and a coincidence occur in the same cycle, the coincidence SHALL belong to the new frame.
- The FSM ends in FIRED.
- The pulse SHALL be emitted next cycle, even if the FSM was FIRED in the old frame.
REQ-018 The three collision FSMs SHALL be independent; simultaneous coincidences of different types SHALL produce simultaneous pulses.
REQ-019 frameCount SHALL increment by 1 on each startOfFrame and wrap from all-ones to 0 with no flag.
REQ-020 Back-to-back startOfFrame cycles SHALL each increment frameCount and each re-arm the FSMs.

Reset
REQ-021 When resetN=0 at a rising clk edge:
- RGBOut=8'h00.
- All hit pulses=0.
- frameCount=0.
- All FSMs=ARMED.
REQ-022 Reset SHALL override startOfFrame and coincidences in the same cycle; no pulse SHALL follow the reset cycle because of that cycle's inputs.
REQ-023 Reset asserted mid-frame with an FSM in FIRED SHALL return it to ARMED, so a coincidence after reset pulses again without needing startOfFrame.
REQ-024 An asynchronous assertion of resetN between clk edges SHALL have no effect until the next rising edge.

Verification
REQ-025 Priority: shotDrawReq=1 (shotRGB=8'hE0), playerDrawReq=1, aliensDrawReq=1, boardersDrawReq=1 -> RGBOut=8'hE0 next cycle. Drop shotDrawReq and bombDrawReq -> RGBOut=playerRGB. All requests 0 with BG_RGB=8'h03 -> RGBOut=8'h03.
REQ-026 Border: only boardersDrawReq=1 -> RGBOut=8'hFC one cycle later.
REQ-027 Once-per-frame: startOfFrame, then shot∧aliens coincidence on 3 separate pixels -> exactly one shotAlienHit pulse, one cycle after the first coincidence. Next startOfFrame then a coincidence -> a new pulse.
REQ-028 Simultaneity: FIRED state, then startOfFrame and bomb∧player in the same cycle -> bombPlayerHit=1 next cycle. A coincidence of all three types in one cycle -> all three pulses high together.
REQ-029 Wrap: 256 startOfFrame pulses with FRAME_CNT_W=8 -> frameCount returns to 0.
REQ-030 Reset mid-operation: frameCount=5 with shotBorder FIRED, then resetN=0 for 1 clk with a coincidence present -> all outputs 0 and frameCount=0. A coincidence after resetN=1 -> a pulse.
